// File: rtl/cuckoo_lookup_pipe.sv
// Multi-channel cuckoo-hash exact-match lookup: rolling hash, T1/T2 index tables,
// dual-read entry table and key compare in four en-gated pipeline stages.
module cuckoo_lookup_pipe #(
    parameter int unsigned PAT_BYTES = 10,
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned HASH_W    = 10,
    parameter int unsigned PTR_W     = 9,
    parameter int unsigned SUFFIX_W  = 2,
    parameter int unsigned CNT_W     = 16,
    localparam int unsigned KEY_W    = 8 * PAT_BYTES,
    localparam int unsigned ENTRY_W  = 1 + SUFFIX_W + KEY_W,
    localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned ADDR_W   = (HASH_W > PTR_W) ? HASH_W : PTR_W,
    localparam int unsigned WDATA_W  = (PTR_W > ENTRY_W) ? PTR_W : ENTRY_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         in_valid,
    input  logic [NUM_CH*HASH_W-1:0]     pre_hash_t1,
    input  logic [NUM_CH*HASH_W-1:0]     pre_hash_t2,
    input  logic [NUM_CH*8-1:0]          hash_byte,
    input  logic [NUM_CH*KEY_W-1:0]      key,
    output logic [NUM_CH*HASH_W-1:0]     hash_t1,
    output logic [NUM_CH*HASH_W-1:0]     hash_t2,
    output logic                         out_valid,
    output logic [NUM_CH-1:0]            hit_a,
    output logic [NUM_CH-1:0]            hit_b,
    output logic [NUM_CH*SUFFIX_W-1:0]   suffix,
    output logic [NUM_CH*PTR_W-1:0]      match_ptr,
    input  logic                         cfg_we,
    input  logic [1:0]                   cfg_sel,
    input  logic [CH_W-1:0]              cfg_ch,
    input  logic [ADDR_W-1:0]            cfg_addr,
    input  logic [WDATA_W-1:0]           cfg_wdata,
    input  logic                         cnt_clr,
    output logic [NUM_CH*CNT_W-1:0]      hit_cnt
);

    logic v1_q, v2_q, v3_q, v4_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            v4_q <= 1'b0;
        end else if (en) begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
            v4_q <= v3_q;
        end
    end

    assign out_valid = v4_q;

    function automatic logic [HASH_W-1:0] roll_hash(input logic [HASH_W-1:0] p,
                                                    input logic [7:0]        b);
        logic [HASH_W-1:0] shl;
        shl = {p[HASH_W-4:0], 3'b000};
        return (shl + (p >> 3) + HASH_W'(b)) ^ p;
    endfunction

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [PTR_W-1:0]    t1_mem  [2**HASH_W];
        logic [PTR_W-1:0]    t2_mem  [2**HASH_W];
        logic [ENTRY_W-1:0]  ent_mem [2**PTR_W];
        logic [HASH_W-1:0]   h1_q, h2_q;
        logic [KEY_W-1:0]    key1_q, key2_q, key3_q;
        logic [PTR_W-1:0]    ptr_a2_q, ptr_b2_q, ptr_a3_q, ptr_b3_q;
        logic [ENTRY_W-1:0]  ent_a3_q, ent_b3_q;
        logic                wr_ch, hit_a_c, hit_b_c;
        logic                hit_a_q, hit_b_q;
        logic [SUFFIX_W-1:0] suffix_q;
        logic [PTR_W-1:0]    match_ptr_q;
        logic [CNT_W-1:0]    cnt_q;

        // Channel indices beyond NUM_CH never match, so such writes are dropped.
        assign wr_ch = cfg_we && (cfg_ch == CH_W'(c));

        always_ff @(posedge clk) begin
            if (wr_ch && cfg_sel == 2'd0) t1_mem[cfg_addr[HASH_W-1:0]] <= cfg_wdata[PTR_W-1:0];
            if (wr_ch && cfg_sel == 2'd1) t2_mem[cfg_addr[HASH_W-1:0]] <= cfg_wdata[PTR_W-1:0];
            if (wr_ch && cfg_sel == 2'd2) ent_mem[cfg_addr[PTR_W-1:0]] <= cfg_wdata[ENTRY_W-1:0];
        end

        // Datapath registers carry no reset; the valid chain qualifies them.
        always_ff @(posedge clk) begin
            if (en) begin
                key1_q   <= key[c*KEY_W +: KEY_W];
                key2_q   <= key1_q;
                key3_q   <= key2_q;
                ptr_a2_q <= t1_mem[h1_q];
                ptr_b2_q <= t2_mem[h2_q];
                ptr_a3_q <= ptr_a2_q;
                ptr_b3_q <= ptr_b2_q;
                ent_a3_q <= ent_mem[ptr_a2_q];
                ent_b3_q <= ent_mem[ptr_b2_q];
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                h1_q <= '0;
                h2_q <= '0;
            end else if (en) begin
                h1_q <= roll_hash(pre_hash_t1[c*HASH_W +: HASH_W], hash_byte[c*8 +: 8]);
                h2_q <= roll_hash(pre_hash_t2[c*HASH_W +: HASH_W], hash_byte[c*8 +: 8]);
            end
        end

        assign hit_a_c = ent_a3_q[ENTRY_W-1] && (ent_a3_q[KEY_W-1:0] == key3_q);
        assign hit_b_c = ent_b3_q[ENTRY_W-1] && (ent_b3_q[KEY_W-1:0] == key3_q);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                hit_a_q     <= 1'b0;
                hit_b_q     <= 1'b0;
                suffix_q    <= '0;
                match_ptr_q <= '0;
            end else if (en) begin
                hit_a_q <= v3_q && hit_a_c;
                hit_b_q <= v3_q && hit_b_c;
                if (v3_q && hit_a_c) begin
                    suffix_q    <= ent_a3_q[KEY_W +: SUFFIX_W];
                    match_ptr_q <= ptr_a3_q;
                end else if (v3_q && hit_b_c) begin
                    suffix_q    <= ent_b3_q[KEY_W +: SUFFIX_W];
                    match_ptr_q <= ptr_b3_q;
                end else begin
                    suffix_q    <= '0;
                    match_ptr_q <= '0;
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt_q <= '0;
            end else if (cnt_clr) begin
                cnt_q <= '0;
            end else if (en && v3_q && (hit_a_c || hit_b_c) && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end

        assign hash_t1[c*HASH_W +: HASH_W]       = h1_q;
        assign hash_t2[c*HASH_W +: HASH_W]       = h2_q;
        assign hit_a[c]                          = hit_a_q;
        assign hit_b[c]                          = hit_b_q;
        assign suffix[c*SUFFIX_W +: SUFFIX_W]    = suffix_q;
        assign match_ptr[c*PTR_W +: PTR_W]       = match_ptr_q;
        assign hit_cnt[c*CNT_W +: CNT_W]         = cnt_q;
    end

endmodule

// File: tb/tb_cuckoo_lookup_pipe.sv
// Directed bench for cuckoo_lookup_pipe (two channels, 2-bit hit counters).
module tb_cuckoo_lookup_pipe;

    logic         clk = 1'b0;
    logic         rst, en, in_valid, cfg_we, cnt_clr;
    logic [19:0]  pre_hash_t1, pre_hash_t2, hash_t1, hash_t2;
    logic [15:0]  hash_byte;
    logic [159:0] key;
    logic         out_valid;
    logic [1:0]   hit_a, hit_b;
    logic [3:0]   suffix;
    logic [17:0]  match_ptr;
    logic [1:0]   cfg_sel;
    logic [0:0]   cfg_ch;
    logic [9:0]   cfg_addr;
    logic [82:0]  cfg_wdata;
    logic [3:0]   hit_cnt;

    int ntests = 0;
    int nfail  = 0;

    localparam logic [79:0] K  = 80'h0102030405060708090A;
    localparam logic [79:0] K2 = 80'h0102030405060708090B;
    localparam logic [79:0] K1 = 80'hA1A2A3A4A5A6A7A8A9AA;
    localparam logic [79:0] KA = 80'h1111111111111111111A;
    localparam logic [79:0] KB = 80'h2222222222222222222B;
    localparam logic [79:0] KC = 80'h3333333333333333333C;

    always #5 clk = ~clk;

    cuckoo_lookup_pipe #(
        .PAT_BYTES(10), .NUM_CH(2), .HASH_W(10), .PTR_W(9), .SUFFIX_W(2), .CNT_W(2)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid),
        .pre_hash_t1(pre_hash_t1), .pre_hash_t2(pre_hash_t2), .hash_byte(hash_byte),
        .key(key), .hash_t1(hash_t1), .hash_t2(hash_t2), .out_valid(out_valid),
        .hit_a(hit_a), .hit_b(hit_b), .suffix(suffix), .match_ptr(match_ptr),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cnt_clr(cnt_clr), .hit_cnt(hit_cnt)
    );

    function automatic logic [82:0] ent(input logic v, input logic [1:0] s,
                                        input logic [79:0] k);
        return {v, s, k};
    endfunction

    task automatic idle();
        in_valid = 1'b0; pre_hash_t1 = '0; pre_hash_t2 = '0; hash_byte = '0; key = '0;
    endtask

    // Channel 1 sits on hash 0 -> T1/T2[0]=0 -> entry 0 (invalid) unless a test says otherwise.
    task automatic issue(input logic [9:0] p1, input logic [9:0] p2, input logic [7:0] b,
                         input logic [79:0] k);
        in_valid = 1'b1;
        pre_hash_t1 = {10'h0, p1}; pre_hash_t2 = {10'h0, p2};
        hash_byte = {8'h0, b}; key = {80'h0, k};
    endtask

    task automatic wr(input logic [1:0] sel, input logic ch, input logic [9:0] addr,
                      input logic [82:0] data);
        cfg_we = 1'b1; cfg_sel = sel; cfg_ch = ch; cfg_addr = addr; cfg_wdata = data;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic wr_ptr(input logic [1:0] sel, input logic [9:0] addr, input logic [8:0] p);
        wr(sel, 1'b0, addr, {74'h0, p});
    endtask

    task automatic pulse_clr();
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b1; cfg_we = 1'b0; cnt_clr = 1'b0;
        cfg_sel = 2'd0; cfg_ch = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        idle();
        repeat (2) @(negedge clk);
        ntests++; if (out_valid !== 1'b0) begin
            nfail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        ntests++; if (hash_t1 !== 20'h0 || hash_t2 !== 20'h0) begin
            nfail++; $display("FAIL reset_hash: got %h/%h want 0/0", hash_t1, hash_t2); end
        ntests++; if (hit_cnt !== 4'h0) begin
            nfail++; $display("FAIL reset_hit_cnt: got %h want 0", hit_cnt); end
        ntests++; if ({hit_a, hit_b, suffix, match_ptr} !== 26'h0) begin
            nfail++; $display("FAIL reset_result: got %h/%h/%h/%h want 0", hit_a, hit_b,
                              suffix, match_ptr); end
        rst = 1'b1;
        @(negedge clk);
        wr(2'd2, 1'b0, 10'h0, '0);
        wr(2'd2, 1'b1, 10'h0, '0);
        wr(2'd0, 1'b1, 10'h0, '0);
        wr(2'd1, 1'b1, 10'h0, '0);
    endtask

    task automatic test_hash();
        in_valid = 1'b0;
        pre_hash_t1 = {10'h001, 10'h3FF};
        pre_hash_t2 = {10'h155, 10'h155};
        hash_byte   = {8'hFF, 8'h41};
        @(negedge clk);
        ntests++; if (hash_t1 !== {10'h106, 10'h347}) begin
            nfail++; $display("FAIL hash_t1: got %h want %h", hash_t1, {10'h106, 10'h347}); end
        ntests++; if (hash_t2 !== {10'h284, 10'h246}) begin
            nfail++; $display("FAIL hash_t2: got %h want %h", hash_t2, {10'h284, 10'h246}); end
        idle();
        @(negedge clk);
    endtask

    task automatic test_single_hit();
        wr_ptr(2'd0, 10'h347, 9'd5);
        wr_ptr(2'd1, 10'h041, 9'd0);
        wr(2'd2, 1'b0, 10'd5, ent(1'b1, 2'b10, K));
        issue(10'h3FF, 10'h000, 8'h41, K);
        @(negedge clk);
        idle();
        repeat (2) @(negedge clk);
        ntests++; if (out_valid !== 1'b0) begin
            nfail++; $display("FAIL single_early: out_valid got %b want 0", out_valid); end
        @(negedge clk);
        ntests++; if (out_valid !== 1'b1) begin
            nfail++; $display("FAIL single_valid: got %b want 1", out_valid); end
        ntests++; if (hit_a !== 2'b01 || hit_b !== 2'b00) begin
            nfail++; $display("FAIL single_hits: got a=%b b=%b want a=01 b=00", hit_a, hit_b); end
        ntests++; if (suffix[1:0] !== 2'b10 || match_ptr[8:0] !== 9'd5) begin
            nfail++; $display("FAIL single_data: got suffix=%b ptr=%0d want 10/5",
                              suffix[1:0], match_ptr[8:0]); end
        ntests++; if (hit_cnt !== 4'b0001) begin
            nfail++; $display("FAIL single_cnt: got %b want 0001", hit_cnt); end
        @(negedge clk);
        ntests++; if (out_valid !== 1'b0) begin
            nfail++; $display("FAIL single_once: out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_both_hit();
        wr_ptr(2'd0, 10'h022, 9'd3);
        wr_ptr(2'd1, 10'h022, 9'd7);
        wr_ptr(2'd0, 10'h023, 9'd0);
        wr_ptr(2'd1, 10'h023, 9'd7);
        wr(2'd2, 1'b0, 10'd3, ent(1'b1, 2'b01, K));
        wr(2'd2, 1'b0, 10'd7, ent(1'b1, 2'b11, K));
        issue(10'h0, 10'h0, 8'h22, K);
        @(negedge clk);
        issue(10'h0, 10'h0, 8'h23, K);
        @(negedge clk);
        idle();
        repeat (2) @(negedge clk);
        ntests++; if (hit_a[0] !== 1'b1 || hit_b[0] !== 1'b1) begin
            nfail++; $display("FAIL both_hits: got a=%b b=%b want 1/1", hit_a[0], hit_b[0]); end
        ntests++; if (suffix[1:0] !== 2'b01 || match_ptr[8:0] !== 9'd3) begin
            nfail++; $display("FAIL both_a_wins: got suffix=%b ptr=%0d want 01/3",
                              suffix[1:0], match_ptr[8:0]); end
        ntests++; if (hit_cnt[1:0] !== 2'd2) begin
            nfail++; $display("FAIL both_cnt: got %0d want 2", hit_cnt[1:0]); end
        @(negedge clk);
        ntests++; if (out_valid !== 1'b1 || hit_a[0] !== 1'b0 || hit_b[0] !== 1'b1) begin
            nfail++; $display("FAIL b_only_hits: got v=%b a=%b b=%b want 1/0/1",
                              out_valid, hit_a[0], hit_b[0]); end
        ntests++; if (suffix[1:0] !== 2'b11 || match_ptr[8:0] !== 9'd7) begin
            nfail++; $display("FAIL b_only_data: got suffix=%b ptr=%0d want 11/7",
                              suffix[1:0], match_ptr[8:0]); end
        ntests++; if (hit_cnt[1:0] !== 2'd3) begin
            nfail++; $display("FAIL b_only_cnt: got %0d want 3", hit_cnt[1:0]); end
        @(negedge clk);
    endtask

    task automatic test_miss_invalid();
        pulse_clr();
        ntests++; if (hit_cnt !== 4'h0) begin
            nfail++; $display("FAIL clr_cnt: got %h want 0", hit_cnt); end
        wr_ptr(2'd0, 10'h024, 9'd3);
        wr_ptr(2'd1, 10'h024, 9'd7);
        wr_ptr(2'd0, 10'h025, 9'd9);
        wr_ptr(2'd1, 10'h025, 9'd0);
        wr(2'd2, 1'b0, 10'd9, ent(1'b0, 2'b10, K));
        issue(10'h0, 10'h0, 8'h24, K2);
        @(negedge clk);
        issue(10'h0, 10'h0, 8'h25, K);
        @(negedge clk);
        idle();
        repeat (2) @(negedge clk);
        ntests++; if (out_valid !== 1'b1 || hit_a !== 2'b00 || hit_b !== 2'b00) begin
            nfail++; $display("FAIL miss_hits: got v=%b a=%b b=%b want 1/00/00",
                              out_valid, hit_a, hit_b); end
        ntests++; if (suffix !== 4'h0 || match_ptr !== 18'h0) begin
            nfail++; $display("FAIL miss_data: got suffix=%h ptr=%h want 0/0", suffix,
                              match_ptr); end
        @(negedge clk);
        ntests++; if (out_valid !== 1'b1 || hit_a !== 2'b00 || hit_b !== 2'b00) begin
            nfail++; $display("FAIL invalid_entry_hits: got v=%b a=%b b=%b want 1/00/00",
                              out_valid, hit_a, hit_b); end
        ntests++; if (match_ptr !== 18'h0 || hit_cnt !== 4'h0) begin
            nfail++; $display("FAIL invalid_entry_data: got ptr=%h cnt=%h want 0/0",
                              match_ptr, hit_cnt); end
        @(negedge clk);
    endtask

    task automatic test_channels();
        wr(2'd2, 1'b1, 10'd0, ent(1'b1, 2'b01, K1));
        wr_ptr(2'd0, 10'h026, 9'd0);
        wr_ptr(2'd1, 10'h026, 9'd0);
        issue(10'h0, 10'h0, 8'h26, K1);
        key[159:80] = K1;
        @(negedge clk);
        idle();
        repeat (3) @(negedge clk);
        ntests++; if (hit_a !== 2'b10 || hit_b !== 2'b10) begin
            nfail++; $display("FAIL chan_hits: got a=%b b=%b want 10/10", hit_a, hit_b); end
        ntests++; if (suffix !== 4'b0100 || match_ptr !== 18'h0) begin
            nfail++; $display("FAIL chan_data: got suffix=%b ptr=%h want 0100/0", suffix,
                              match_ptr); end
        ntests++; if (hit_cnt !== 4'b0100) begin
            nfail++; $display("FAIL chan_cnt: got %b want 0100", hit_cnt); end
        wr(2'd2, 1'b1, 10'd0, '0);
    endtask

    task automatic test_stall();
        pulse_clr();
        wr_ptr(2'd0, 10'h010, 9'd11);
        wr_ptr(2'd0, 10'h020, 9'd12);
        wr_ptr(2'd0, 10'h030, 9'd13);
        wr_ptr(2'd1, 10'h010, 9'd0);
        wr_ptr(2'd1, 10'h020, 9'd0);
        wr_ptr(2'd1, 10'h030, 9'd0);
        wr(2'd2, 1'b0, 10'd11, ent(1'b1, 2'b01, KA));
        wr(2'd2, 1'b0, 10'd12, ent(1'b1, 2'b10, KB));
        wr(2'd2, 1'b0, 10'd13, ent(1'b1, 2'b11, KC));
        issue(10'h0, 10'h0, 8'h10, KA);
        @(negedge clk);
        issue(10'h0, 10'h0, 8'h20, KB);
        @(negedge clk);
        issue(10'h0, 10'h0, 8'h30, KC);
        @(negedge clk);
        idle();
        @(negedge clk);
        ntests++; if (out_valid !== 1'b1 || match_ptr[8:0] !== 9'd11) begin
            nfail++; $display("FAIL stall_first: got v=%b ptr=%0d want 1/11", out_valid,
                              match_ptr[8:0]); end
        en = 1'b0;
        issue(10'h0, 10'h0, 8'h10, KA);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ntests++; if (out_valid !== 1'b1 || match_ptr[8:0] !== 9'd11
                          || suffix[1:0] !== 2'b01) begin
                nfail++; $display("FAIL stall_hold[%0d]: got v=%b ptr=%0d sfx=%b want 1/11/01",
                                  i, out_valid, match_ptr[8:0], suffix[1:0]); end
            ntests++; if (hit_cnt[1:0] !== 2'd1 || hash_t1[9:0] !== 10'h0) begin
                nfail++; $display("FAIL stall_regs[%0d]: got cnt=%0d h1=%h want 1/000",
                                  i, hit_cnt[1:0], hash_t1[9:0]); end
        end
        en = 1'b1;
        idle();
        @(negedge clk);
        ntests++; if (out_valid !== 1'b1 || match_ptr[8:0] !== 9'd12 || suffix[1:0] !== 2'b10
                      || hit_cnt[1:0] !== 2'd2) begin
            nfail++; $display("FAIL stall_second: got v=%b ptr=%0d sfx=%b cnt=%0d want 1/12/10/2",
                              out_valid, match_ptr[8:0], suffix[1:0], hit_cnt[1:0]); end
        @(negedge clk);
        ntests++; if (out_valid !== 1'b1 || match_ptr[8:0] !== 9'd13 || suffix[1:0] !== 2'b11
                      || hit_cnt[1:0] !== 2'd3) begin
            nfail++; $display("FAIL stall_third: got v=%b ptr=%0d sfx=%b cnt=%0d want 1/13/11/3",
                              out_valid, match_ptr[8:0], suffix[1:0], hit_cnt[1:0]); end
        repeat (2) begin
            @(negedge clk);
            ntests++; if (out_valid !== 1'b0) begin
                nfail++; $display("FAIL stall_extra: out_valid got %b want 0", out_valid); end
        end
    endtask

    task automatic test_saturation();
        int exp;
        pulse_clr();
        for (int i = 0; i < 9; i++) begin
            if (i >= 4) begin
                exp = (i - 3 > 3) ? 3 : i - 3;
                ntests++; if (hit_cnt[1:0] !== 2'(exp)) begin
                    nfail++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, hit_cnt[1:0],
                                      exp); end
            end
            if (i < 5) issue(10'h0, 10'h0, 8'h10, KA);
            else idle();
            @(negedge clk);
        end
    endtask

    task automatic test_clr_coincident();
        pulse_clr();
        issue(10'h0, 10'h0, 8'h10, KA);
        @(negedge clk);
        issue(10'h0, 10'h0, 8'h10, KA);
        @(negedge clk);
        idle();
        repeat (2) @(negedge clk);
        ntests++; if (hit_cnt[1:0] !== 2'd1) begin
            nfail++; $display("FAIL clr_pre: got %0d want 1", hit_cnt[1:0]); end
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        ntests++; if (out_valid !== 1'b1 || hit_a[0] !== 1'b1 || hit_cnt[1:0] !== 2'd0) begin
            nfail++; $display("FAIL clr_priority: got v=%b a=%b cnt=%0d want 1/1/0",
                              out_valid, hit_a[0], hit_cnt[1:0]); end
        @(negedge clk);
    endtask

    task automatic test_reset_midflight();
        issue(10'h0, 10'h0, 8'h10, KA);
        @(negedge clk);
        issue(10'h0, 10'h0, 8'h20, KB);
        @(negedge clk);
        idle();
        repeat (2) @(negedge clk);
        ntests++; if (out_valid !== 1'b1 || hit_cnt[1:0] !== 2'd1) begin
            nfail++; $display("FAIL rst_pre: got v=%b cnt=%0d want 1/1", out_valid,
                              hit_cnt[1:0]); end
        #2 rst = 1'b0;
        #1;
        ntests++; if (out_valid !== 1'b0 || hit_cnt !== 4'h0) begin
            nfail++; $display("FAIL rst_async: got v=%b cnt=%h want 0/0", out_valid, hit_cnt); end
        ntests++; if (hit_a !== 2'b00 || match_ptr !== 18'h0 || suffix !== 4'h0) begin
            nfail++; $display("FAIL rst_async_data: got a=%b ptr=%h sfx=%h want 0", hit_a,
                              match_ptr, suffix); end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ntests++; if (out_valid !== 1'b0) begin
                nfail++; $display("FAIL rst_stale[%0d]: out_valid got %b want 0", i,
                                  out_valid); end
        end
        issue(10'h0, 10'h0, 8'h30, KC);
        @(negedge clk);
        idle();
        repeat (3) @(negedge clk);
        ntests++; if (out_valid !== 1'b1 || match_ptr[8:0] !== 9'd13) begin
            nfail++; $display("FAIL rst_recover: got v=%b ptr=%0d want 1/13", out_valid,
                              match_ptr[8:0]); end
        @(negedge clk);
    endtask

    task automatic test_collision();
        wr_ptr(2'd0, 10'h050, 9'd5);
        wr_ptr(2'd1, 10'h050, 9'd0);
        wr(2'd2, 1'b0, 10'd5, ent(1'b1, 2'b10, K));
        issue(10'h0, 10'h0, 8'h50, K);
        @(negedge clk);
        idle();
        @(negedge clk);
        cfg_we = 1'b1; cfg_sel = 2'd2; cfg_ch = 1'b0; cfg_addr = 10'd5;
        cfg_wdata = ent(1'b1, 2'b01, K);
        @(negedge clk);
        cfg_we = 1'b0;
        @(negedge clk);
        ntests++; if (out_valid !== 1'b1 || hit_a[0] !== 1'b1 || suffix[1:0] !== 2'b10) begin
            nfail++; $display("FAIL coll_old: got v=%b a=%b sfx=%b want 1/1/10", out_valid,
                              hit_a[0], suffix[1:0]); end
        issue(10'h0, 10'h0, 8'h50, K);
        @(negedge clk);
        idle();
        repeat (3) @(negedge clk);
        ntests++; if (out_valid !== 1'b1 || suffix[1:0] !== 2'b01) begin
            nfail++; $display("FAIL coll_new: got v=%b sfx=%b want 1/01", out_valid,
                              suffix[1:0]); end
        wr(2'd3, 1'b0, 10'd5, ent(1'b1, 2'b00, K));
        issue(10'h0, 10'h0, 8'h50, K);
        @(negedge clk);
        idle();
        repeat (3) @(negedge clk);
        ntests++; if (out_valid !== 1'b1 || suffix[1:0] !== 2'b01) begin
            nfail++; $display("FAIL sel3_nowrite: got v=%b sfx=%b want 1/01", out_valid,
                              suffix[1:0]); end
    endtask

    initial begin
        test_reset();
        test_hash();
        test_single_hit();
        test_both_hit();
        test_miss_invalid();
        test_channels();
        test_stall();
        test_saturation();
        test_clr_coincident();
        test_reset_midflight();
        test_collision();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d checks done", ntests);
        $fatal(1, "timeout");
    end

endmodule
